// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES byte framer.
// Block geometry and framer state encoding.
package aes_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_FIRE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/aes_byte_serializer.sv
// Turns a 128-bit block into 16 big-endian bytes
// over a valid/ready stream, flagging the last byte.
module aes_byte_serializer
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [BLOCK_W-1:0] i_data,
    output logic [BYTE_W-1:0]  o_byte,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_done
);

    logic [BLOCK_W-1:0] r_data;
    logic [3:0]         r_idx;
    logic               r_valid;
    logic               w_last;

    assign w_last  = (r_idx == 4'(BLOCK_BYTES - 1));
    assign o_valid = r_valid;
    assign o_last  = r_valid & w_last;
    assign o_done  = r_valid & i_ready & w_last;
    assign o_byte  = r_data[(BLOCK_W - 1) - BYTE_W * int'(r_idx) -: BYTE_W];

    // Hold the block; step the byte index on each accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            if (w_last) begin
                r_idx   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/aes_byte_framer.sv
// Byte-stream framer around a 128-bit AES decryptor:
// collects key/ciphertext blocks, fires, waits, drains plaintext.
module aes_byte_framer
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BYTE_W-1:0]  in_byte,
    input  logic               in_valid,
    input  logic               in_is_key,
    output logic               in_ready,
    output logic               aes_start,
    output logic [BLOCK_W-1:0] aes_key,
    output logic [BLOCK_W-1:0] aes_ciphertext,
    input  logic               aes_valid,
    input  logic [BLOCK_W-1:0] aes_plaintext,
    output logic [BYTE_W-1:0]  out_byte,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               err_nokey,
    output logic               err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_idx;
    logic               r_is_key;
    logic               r_key_loaded;
    logic [BLOCK_W-1:0] r_buf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_nokey;
    logic               r_tmo;

    logic               w_acc;
    logic               w_switch;
    logic [3:0]         w_pos;
    logic               w_type;
    logic               w_full;
    logic [BLOCK_W-1:0] w_blk;
    logic               w_load;
    logic               w_tmo;
    logic               w_done;

    assign in_ready    = rst_n & (r_state == ST_COLLECT);
    assign busy        = (r_state != ST_COLLECT);
    assign aes_start   = (r_state == ST_FIRE);
    assign err_nokey   = r_nokey;
    assign err_timeout = r_tmo;

    // A type change mid-block restarts the block at index 0.
    assign w_acc    = in_valid & in_ready;
    assign w_switch = (r_idx != 4'd0) && (in_is_key != r_is_key);
    assign w_pos    = w_switch ? 4'd0 : r_idx;
    assign w_type   = (w_pos == 4'd0) ? in_is_key : r_is_key;
    assign w_full   = (w_pos == 4'(BLOCK_BYTES - 1));

    // Block buffer with the incoming byte merged in, big-endian.
    always_comb begin
        w_blk = r_buf;
        w_blk[(BLOCK_W - 1) - BYTE_W * int'(w_pos) -: BYTE_W] = in_byte;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_COLLECT;
        else        r_state <= w_next;
    end

    // Next-state and serializer load/timeout strobes.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_tmo  = 1'b0;
        unique case (r_state)
            ST_COLLECT: begin
                if (w_acc && w_full && !w_type && r_key_loaded)
                    w_next = ST_FIRE;
            end
            ST_FIRE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (aes_valid) begin
                    w_load = 1'b1;
                    w_next = ST_DRAIN;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_tmo  = 1'b1;
                    w_next = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (w_done) w_next = ST_COLLECT;
            end
            default: w_next = ST_COLLECT;
        endcase
    end

    // Byte collection, key/ciphertext registers, error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= '0;
            r_is_key       <= 1'b0;
            r_key_loaded   <= 1'b0;
            r_buf          <= '0;
            aes_key        <= '0;
            aes_ciphertext <= '0;
            r_nokey        <= 1'b0;
            r_tmo          <= 1'b0;
        end else begin
            r_nokey <= 1'b0;
            r_tmo   <= w_tmo;
            if (w_acc) begin
                r_buf    <= w_blk;
                r_is_key <= w_type;
                r_idx    <= w_full ? 4'd0 : w_pos + 4'd1;
                if (w_full) begin
                    if (w_type) begin
                        aes_key      <= w_blk;
                        r_key_loaded <= 1'b1;
                    end else if (r_key_loaded) begin
                        aes_ciphertext <= w_blk;
                    end else begin
                        r_nokey <= 1'b1;
                    end
                end
            end
        end
    end

    // Wait-cycle counter, live only in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_cnt <= '0;
        else if (r_state == ST_WAIT) r_cnt <= r_cnt + CNT_W'(1);
        else                       r_cnt <= '0;
    end

    aes_byte_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (aes_plaintext),
        .o_byte  (out_byte),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_last  (out_last),
        .o_done  (w_done)
    );

endmodule

// File: tb/tb_aes_byte_framer.sv
// Directed bench for aes_byte_framer with a queue-based
// block model and a stand-in decryptor.
module tb_aes_byte_framer;

    localparam int TO = 16;
    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] C2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [7:0]   in_byte = '0;
    logic         in_valid = 1'b0;
    logic         in_is_key = 1'b0;
    logic         in_ready;
    logic         aes_start;
    logic [127:0] aes_key;
    logic [127:0] aes_ciphertext;
    logic         aes_valid = 1'b0;
    logic [127:0] aes_plaintext = '0;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic         busy;
    logic         err_nokey;
    logic         err_timeout;

    aes_byte_framer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_byte        (in_byte),
        .in_valid       (in_valid),
        .in_is_key      (in_is_key),
        .in_ready       (in_ready),
        .aes_start      (aes_start),
        .aes_key        (aes_key),
        .aes_ciphertext (aes_ciphertext),
        .aes_valid      (aes_valid),
        .aes_plaintext  (aes_plaintext),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .err_nokey      (err_nokey),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string name, input logic [127:0] act,
                          input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state
    logic [7:0]   m_blk[$];
    bit           m_type;
    bit           m_loaded;
    logic [127:0] m_key = '0;
    logic [127:0] m_ct = '0;
    longint       m_acc_cyc = -10;
    longint       start_cyc = -100;
    int           exp_starts = 0, exp_nokey = 0, exp_tmo = 0;
    int           obs_starts = 0, obs_nokey = 0, obs_tmo = 0;
    logic [7:0]   exp_q[$];
    int           exp_pos = 0;
    logic [7:0]   rx_q[$];
    logic [7:0]   last_byte = '0;
    bit           busy_seen = 0;
    int           dec_lat = 5;
    bit           poke = 0;
    bit           rnd_mode = 0;

    task automatic model_accept(input logic [7:0] b, input bit k);
        logic [127:0] v;
        if (m_blk.size() != 0 && k != m_type) m_blk.delete();
        if (m_blk.size() == 0) m_type = k;
        m_blk.push_back(b);
        if (m_blk.size() == 16) begin
            v = '0;
            foreach (m_blk[i]) v = {v[119:0], m_blk[i]};
            m_blk.delete();
            if (k) begin
                m_key = v;
                m_loaded = 1;
            end else if (m_loaded) begin
                m_ct = v;
                exp_starts++;
            end else begin
                exp_nokey++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit k);
        bit got = 0;
        longint c = 0;
        in_byte = b;
        in_is_key = k;
        in_valid = 1'b1;
        for (int t = 0; t < 500 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            c = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) chk_eq("in_ready_wait", 0, 1);
        else begin
            m_acc_cyc = c;
            model_accept(b, k);
        end
    endtask

    task automatic send_block(input logic [127:0] v, input bit k, input int n);
        for (int i = 0; i < n; i++) send_byte(v[127 - 8*i -: 8], k);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            #1;
            done = (exp_q.size() == 0) && !busy;
        end
        if (!done) chk_eq("idle_wait", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        chk_eq("starts", obs_starts, exp_starts);
        chk_eq("nokey", obs_nokey, exp_nokey);
        chk_eq("timeouts", obs_tmo, exp_tmo);
        chk_eq("pending_out", exp_q.size(), 0);
    endtask

    // Sink handshake pattern.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Stand-in decryptor: fixed latency, FIPS-197 vector or a scramble.
    initial forever begin
        logic [127:0] p;
        int lat;
        @(negedge clk);
        if (poke) begin
            poke = 0;
            @(posedge clk);
            #1;
            aes_valid = 1'b1;
            aes_plaintext = {4{32'hdeadbeef}};
            @(posedge clk);
            #1;
            aes_valid = 1'b0;
        end else if (rst_n && aes_start) begin
            lat = dec_lat;
            if (aes_key == FK && aes_ciphertext == FC) p = FP;
            else p = aes_ciphertext ^ aes_key ^ {16{8'h5a}};
            if (lat == 0 || lat > TO) exp_tmo++;
            else for (int i = 0; i < 16; i++) exp_q.push_back(p[127 - 8*i -: 8]);
            if (lat != 0) begin
                repeat (lat) @(posedge clk);
                #1;
                aes_valid = 1'b1;
                aes_plaintext = p;
                @(posedge clk);
                #1;
                aes_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk_eq("ready_vs_busy", in_ready, !busy);
            if (busy) begin
                busy_seen = 1;
                chk_eq("hold_key", aes_key, m_key);
                chk_eq("hold_ct", aes_ciphertext, m_ct);
            end
            if (aes_start) begin
                obs_starts++;
                start_cyc = cyc;
                chk_eq("start_cycle", cyc, m_acc_cyc + 1);
            end
            if (err_nokey) begin
                obs_nokey++;
                chk_eq("nokey_cycle", cyc, m_acc_cyc + 1);
            end
            if (err_timeout) begin
                obs_tmo++;
                chk_eq("timeout_cycle", cyc, start_cyc + TO + 1);
                chk_eq("timeout_busy", busy, 0);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) chk_eq("spurious_out", out_valid, 0);
                else begin
                    chk_eq("out_byte", out_byte, exp_q[0]);
                    chk_eq("out_last", out_last, exp_pos == 15);
                    if (out_ready) begin
                        rx_q.push_back(out_byte);
                        if (out_last) last_byte = out_byte;
                        void'(exp_q.pop_front());
                        exp_pos = (exp_pos + 1) % 16;
                    end
                end
            end else begin
                chk_eq("last_idle", out_last, 0);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk_eq({tag, "_out_valid"}, out_valid, 0);
        chk_eq({tag, "_out_byte"}, out_byte, 0);
        chk_eq({tag, "_out_last"}, out_last, 0);
        chk_eq({tag, "_start"}, aes_start, 0);
        chk_eq({tag, "_key"}, aes_key, 0);
        chk_eq({tag, "_ct"}, aes_ciphertext, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_nokey"}, err_nokey, 0);
        chk_eq({tag, "_tmo"}, err_timeout, 0);
        chk_eq({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        bit hit;
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_eq("post_reset_ready", in_ready, 1);
        chk_eq("post_reset_busy", busy, 0);
        @(posedge clk);
        #1;

        // Ciphertext with no key loaded.
        busy_seen = 0;
        send_block(FC, 0, 16);
        repeat (4) @(posedge clk);
        #1;
        check_counts();
        chk_eq("nokey_literal", obs_nokey, 1);
        chk_eq("nokey_no_busy", busy_seen, 0);

        // Partial key dropped by a ciphertext block.
        send_block(FK, 1, 8);
        send_block(FC, 0, 16);
        repeat (4) @(posedge clk);
        #1;
        check_counts();
        chk_eq("partial_key_literal", obs_nokey, 2);
        chk_eq("partial_no_busy", busy_seen, 0);

        // Stray aes_valid while collecting, then the FIPS vector.
        poke = 1;
        repeat (4) @(posedge clk);
        #1;
        rx_q.delete();
        send_block(FK, 1, 16);
        send_block(FC, 0, 16);
        dec_lat = 5;
        wait_idle();
        check_counts();
        chk_eq("fips_count", rx_q.size(), 16);
        if (rx_q.size() == 16) begin
            chk_eq("fips_b0", rx_q[0], 8'h00);
            chk_eq("fips_b7", rx_q[7], 8'h77);
            chk_eq("fips_b15", rx_q[15], 8'hff);
        end
        chk_eq("fips_last", last_byte, 8'hff);
        chk_eq("fips_one_start", obs_starts, 1);

        // Persisting key, valid on the final WAIT cycle, stalling sink.
        rnd_mode = 1;
        dec_lat = TO;
        send_block(C2, 0, 16);
        wait_idle();
        rnd_mode = 0;
        check_counts();

        // No response, then a response one cycle too late.
        dec_lat = 0;
        send_block(C2, 0, 16);
        wait_idle();
        dec_lat = TO + 1;
        send_block(FC, 0, 16);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check_counts();
        chk_eq("timeout_literal", obs_tmo, 2);

        // Ciphertext fragment cut by a new key block.
        dec_lat = 1;
        send_block(FC, 0, 5);
        send_block(K2, 1, 16);
        send_block(FC, 0, 16);
        wait_idle();
        check_counts();

        // Reset in the middle of draining.
        dec_lat = 3;
        send_block(FK, 1, 16);
        send_block(FC, 0, 16);
        hit = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge clk);
            #1;
            hit = (exp_pos == 7) && out_valid;
        end
        chk_eq("drain_reached_7", hit, 1);
        rst_n = 1'b0;
        #1 check_zero("mid_drain");
        exp_q.delete();
        exp_pos = 0;
        m_blk.delete();
        m_loaded = 0;
        m_key = '0;
        m_ct = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rel_ready", in_ready, 1);
        chk_eq("rel_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rx_q.delete();
        send_block(FK, 1, 16);
        send_block(FC, 0, 16);
        wait_idle();
        check_counts();
        chk_eq("rerun_count", rx_q.size(), 16);
        chk_eq("rerun_last", last_byte, 8'hff);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        n_errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
